dice_roll_sequencer: RTL

//  Synthesizable, parametrised roll-stimulus engine for the dice-game controller.
//  - Drives the controller's roll button (Rb) and dice sum (Sum).
//  - Waits for the controller's Roll request, then checks Win/Lose and pulses GameReset.
//  - Sum source is a loadable table or an LFSR two-dice generator, with single-pass or loop mode.
//  - Keeps win/lose statistics and a Roll-timeout watchdog. Sits beside the dice controller in both bench and FPGA top.

---
 rtl/dice_pkg.sv | 27 ++
 rtl/dice_roll_sequencer_if.sv | 18 +
 rtl/dice_lfsr.sv | 30 +++
 rtl/dice_roll_sequencer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/dice_pkg.sv
// Shared types and constants for the dice roll sequencer and its LFSR dice source.
package dice_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PRESS   = 3'd1,
        RELEASE = 3'd2,
        CHECK   = 3'd3,
        RSTG    = 3'd4,
        DONE    = 3'd5,
        ERR     = 3'd6
    } state_t;

    localparam int          DIE_FACES = 6;
    localparam int          MIN_SUM   = 2;
    localparam int          MAX_SUM   = 12;
    // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Maps a 3-bit raw value onto a die face 1..6 as (raw % 6) + 1.
    function automatic logic [2:0] die_value(input logic [2:0] raw);
        logic [2:0] r;
        r = (raw >= 3'(DIE_FACES)) ? raw - 3'(DIE_FACES) : raw;
        return r + 3'd1;
    endfunction

endpackage

// File: rtl/dice_roll_sequencer_if.sv
// Link between the roll sequencer (master) and the dice-game controller (slave).
interface dice_roll_sequencer_if #(
    parameter int SUM_W = 4
);
    // Rb=1 is a standing roll request; the controller acknowledges with Roll,
    // which the sequencer consumes on the first cycle it is seen high while
    // pressing. Sum is valid from the cycle after that acknowledge, and
    // Win/Lose are only sampled in the single check cycle that follows.
    logic             Rb;
    logic [SUM_W-1:0] Sum;
    logic             GameReset;
    logic             Roll;
    logic             Win;
    logic             Lose;

    modport master (output Rb, Sum, GameReset, input Roll, Win, Lose);
    modport slave  (input Rb, Sum, GameReset, output Roll, Win, Lose);
endinterface

// File: rtl/dice_lfsr.sv
// 16-bit Fibonacci LFSR turned into two dice faces and their sum.
module dice_lfsr
    import dice_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       load,
    input  logic       step,
    output logic [2:0] die_a,
    output logic [2:0] die_b,
    output logic [3:0] sum
);

    logic [15:0] lfsr;

    always_ff @(posedge CLK) begin
        if (Reset || load) begin
            lfsr <= SEED;
        end else if (step) begin
            lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
        end
    end

    assign die_a = die_value(lfsr[2:0]);
    assign die_b = die_value(lfsr[5:3]);
    assign sum   = {1'b0, die_a} + {1'b0, die_b};

endmodule

// File: rtl/dice_roll_sequencer.sv
// Roll-stimulus engine: presses Rb, feeds Sum from a table or LFSR dice, scores Win/Lose.
module dice_roll_sequencer
    import dice_pkg::*;
#(
    parameter int          SUM_W       = 4,
    parameter int          DEPTH       = 12,
    parameter int          HOLD_CYCLES = 1,
    parameter int          TIMEOUT     = 255,
    parameter int          CNT_W       = 8,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                     CLK,
    input  logic                     Reset,
    input  logic                     Start,
    input  logic                     Mode,
    input  logic                     Loop,
    input  logic                     TblWe,
    input  logic [$clog2(DEPTH)-1:0] TblAddr,
    input  logic [SUM_W-1:0]         TblData,
    dice_roll_sequencer_if.master    bus,
    output logic                     Busy,
    output logic                     Done,
    output logic                     TimeoutErr,
    output logic                     BothErr,
    output logic [CNT_W-1:0]         WinCount,
    output logic [CNT_W-1:0]         LoseCount,
    output state_t                   State
);

    localparam int AW = $clog2(DEPTH);
    localparam int IW = $clog2(DEPTH + 1);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WW-1:0]    wd_q, wd_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic             mode_q, mode_d, loop_q, loop_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] win_q, win_d, lose_q, lose_d;
    logic             tmo_q, tmo_d, both_q, both_d;
    logic             rb_q, grst_q, busy_q, done_q;
    logic             lfsr_load, lfsr_step, advance;
    logic [2:0]       die_a, die_b;
    logic [3:0]       lfsr_sum;
    logic [5:0]       dice_unused;
    logic [SUM_W-1:0] tbl [DEPTH];

    dice_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .CLK   (CLK),
        .Reset (Reset),
        .load  (lfsr_load),
        .step  (lfsr_step),
        .die_a (die_a),
        .die_b (die_b),
        .sum   (lfsr_sum)
    );

    // Individual faces are only needed when probing the generator.
    assign dice_unused = {die_a, die_b};

    // Table is deliberately not reset; writes are locked out while a pass runs.
    always_ff @(posedge CLK) begin
        if (TblWe && !busy_q && (int'(TblAddr) < DEPTH)) begin
            tbl[TblAddr] <= TblData;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        wd_d      = wd_q;
        hold_d    = hold_q;
        mode_d    = mode_q;
        loop_d    = loop_q;
        sum_d     = sum_q;
        win_d     = win_q;
        lose_d    = lose_q;
        tmo_d     = tmo_q;
        both_d    = both_q;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        advance   = 1'b0;

        case (state_q)
            IDLE, DONE, ERR: begin
                if (Start) begin
                    state_d   = PRESS;
                    idx_d     = '0;
                    wd_d      = '0;
                    win_d     = '0;
                    lose_d    = '0;
                    tmo_d     = 1'b0;
                    both_d    = 1'b0;
                    mode_d    = Mode;
                    loop_d    = Loop;
                    lfsr_load = 1'b1;
                end
            end
            PRESS: begin
                // A Roll on the timeout cycle still wins over the watchdog.
                if (bus.Roll) begin
                    sum_d     = mode_q ? SUM_W'(lfsr_sum) : tbl[idx_q[AW-1:0]];
                    idx_d     = idx_q + 1'b1;
                    lfsr_step = 1'b1;
                    hold_d    = '0;
                    state_d   = RELEASE;
                end else if (wd_q == WW'(TIMEOUT)) begin
                    tmo_d   = 1'b1;
                    state_d = ERR;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            RELEASE: begin
                if (hold_q == HW'(HOLD_CYCLES - 1)) begin
                    state_d = CHECK;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            CHECK: begin
                if (bus.Win && bus.Lose) begin
                    both_d  = 1'b1;
                    state_d = RSTG;
                end else if (bus.Win) begin
                    if (win_q != '1) win_d = win_q + 1'b1;
                    state_d = RSTG;
                end else if (bus.Lose) begin
                    if (lose_q != '1) lose_d = lose_q + 1'b1;
                    state_d = RSTG;
                end else begin
                    advance = 1'b1;
                end
            end
            RSTG:    advance = 1'b1;
            default: state_d = IDLE;
        endcase

        // Next-roll decision folds into the CHECK/RSTG cycle itself.
        if (advance) begin
            wd_d = '0;
            if (idx_q == IW'(DEPTH)) begin
                if (loop_q) begin
                    idx_d   = '0;
                    state_d = PRESS;
                end else begin
                    state_d = DONE;
                end
            end else begin
                state_d = PRESS;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            wd_q    <= '0;
            hold_q  <= '0;
            mode_q  <= 1'b0;
            loop_q  <= 1'b0;
            sum_q   <= '0;
            win_q   <= '0;
            lose_q  <= '0;
            tmo_q   <= 1'b0;
            both_q  <= 1'b0;
            rb_q    <= 1'b0;
            grst_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wd_q    <= wd_d;
            hold_q  <= hold_d;
            mode_q  <= mode_d;
            loop_q  <= loop_d;
            sum_q   <= sum_d;
            win_q   <= win_d;
            lose_q  <= lose_d;
            tmo_q   <= tmo_d;
            both_q  <= both_d;
            rb_q    <= (state_d == PRESS);
            grst_q  <= (state_d == RSTG);
            busy_q  <= (state_d inside {PRESS, RELEASE, CHECK, RSTG});
            done_q  <= (state_d == DONE);
        end
    end

    assign bus.Rb        = rb_q;
    assign bus.Sum       = sum_q;
    assign bus.GameReset = grst_q;
    assign Busy          = busy_q;
    assign Done          = done_q;
    assign TimeoutErr    = tmo_q;
    assign BothErr       = both_q;
    assign WinCount      = win_q;
    assign LoseCount     = lose_q;
    assign State         = state_q;

endmodule
